exec_stage_mc: RTL

//  Parametrised pipeline EXECUTE stage: operand forwarding, single-cycle ALU, iterative multi-cycle MULU/DIVU.

---
 rtl/exe_pkg.sv | 55 +++++
 rtl/exec_stage_mc_if.sv | 60 ++++++
 rtl/exe_muldiv_iter.sv | 118 +++++++++++
 rtl/exec_stage_mc.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/exe_pkg.sv
// ---------------------------------------------------------------------------
// exe_pkg
// Shared types for the execute stage: ALU opcode encoding, the stage FSM
// state type, operand-forwarding select codes and a helper that tells which
// opcodes are handled by the iterative multiply/divide engine.
// Optional feature macro: EXE_DIV_EN (adds the DIV state and makes DIVU a
// multi-cycle op).
// ---------------------------------------------------------------------------
package exe_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_NOR  = 4'h5,
        ALU_SLT  = 4'h6,
        ALU_SLTU = 4'h7,
        ALU_SLL  = 4'h8,
        ALU_SRL  = 4'h9,
        ALU_SRA  = 4'hA,
        ALU_LUI  = 4'hB,
        ALU_MULU = 4'hC,
        ALU_DIVU = 4'hD
    } alu_op_t;

`ifdef EXE_DIV_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1
    } state_t;
`endif

    // Where a source operand comes from.
    localparam logic [1:0] SEL_RF  = 2'd0;
    localparam logic [1:0] SEL_MEM = 2'd1;
    localparam logic [1:0] SEL_WB  = 2'd2;

    // True for opcodes that run on the iterative engine in this build.
    function automatic logic is_multi(input alu_op_t op);
`ifdef EXE_DIV_EN
        return (op == ALU_MULU) || (op == ALU_DIVU);
`else
        return (op == ALU_MULU);
`endif
    endfunction

endpackage

// File: rtl/exec_stage_mc_if.sv
// ---------------------------------------------------------------------------
// exec_stage_mc_if
// Bundles the ID/EX input side, the forwarding taps from MEM/WB, and the
// EX/MEM output side of the execute stage.
//   slave  : the execute stage (consumes ID/EX + taps, produces EX/MEM)
//   master : whoever drives the stage (pipeline glue or a testbench)
// Parameters: W datapath width, RW register-index width.
// ---------------------------------------------------------------------------
interface exec_stage_mc_if #(
    parameter int W  = 32,
    parameter int RW = 5
);
    logic          flush_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [3:0]    op_i;
    logic          use_imm_i;
    logic [W-1:0]  pc_i;
    logic [W-1:0]  rs_val_i;
    logic [W-1:0]  rt_val_i;
    logic [W-1:0]  imm_i;
    logic [RW-1:0] rs_i;
    logic [RW-1:0] rt_i;
    logic [RW-1:0] dst_i;
    logic [1:0]    wb_ctl_i;
    logic [2:0]    mem_ctl_i;
    logic [RW-1:0] mem_rd_i;
    logic          mem_wr_i;
    logic [W-1:0]  mem_val_i;
    logic [RW-1:0] wb_rd_i;
    logic          wb_wr_i;
    logic [W-1:0]  wb_val_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [W-1:0]  result_o;
    logic [W-1:0]  hi_o;
    logic          zero_o;
    logic [W-1:0]  br_target_o;
    logic [W-1:0]  store_val_o;
    logic [RW-1:0] dst_o;
    logic [1:0]    wb_ctl_o;
    logic [2:0]    mem_ctl_o;
    logic          ill_o;

    modport slave (
        input  flush_i, in_valid_i, op_i, use_imm_i, pc_i, rs_val_i, rt_val_i,
               imm_i, rs_i, rt_i, dst_i, wb_ctl_i, mem_ctl_i, mem_rd_i,
               mem_wr_i, mem_val_i, wb_rd_i, wb_wr_i, wb_val_i, out_ready_i,
        output in_ready_o, out_valid_o, result_o, hi_o, zero_o, br_target_o,
               store_val_o, dst_o, wb_ctl_o, mem_ctl_o, ill_o
    );

    modport master (
        output flush_i, in_valid_i, op_i, use_imm_i, pc_i, rs_val_i, rt_val_i,
               imm_i, rs_i, rt_i, dst_i, wb_ctl_i, mem_ctl_i, mem_rd_i,
               mem_wr_i, mem_val_i, wb_rd_i, wb_wr_i, wb_val_i, out_ready_i,
        input  in_ready_o, out_valid_o, result_o, hi_o, zero_o, br_target_o,
               store_val_o, dst_o, wb_ctl_o, mem_ctl_o, ill_o
    );
endinterface

// File: rtl/exe_muldiv_iter.sv
// ---------------------------------------------------------------------------
// exe_muldiv_iter
// Iterative unsigned multiply (shift-add) / divide (restoring) engine, one
// bit per clock, W iterations.
// Ports:
//   clk, rst        clock / async active-high reset
//   flush_i         abort the running operation
//   start_i, div_i  load operands and start; div_i selects divide
//   a_i             multiplier / dividend
//   b_i             multiplicand / divisor
//   busy_o          an operation is in progress
//   done_o          this cycle's edge completes the last iteration
//   lo_o, hi_o      next register values; the final product/quotient and
//                   high word/remainder while done_o is high
// ---------------------------------------------------------------------------
module exe_muldiv_iter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic         start_i,
    input  logic         div_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [W-1:0] lo_o,
    output logic [W-1:0] hi_o
);
    localparam int CW = $clog2(W) + 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    logic          busy_q, busy_d;
    logic          div_q, div_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  lo_q, lo_d;
    logic [W-1:0]  hi_q, hi_d;
    logic [W:0]    sum;
    logic [W:0]    shifted;
    logic [W:0]    trial;

    // hi:lo is the product accumulator (multiply) or remainder:quotient
    // shift pair (divide). A zero divisor needs no special case: every
    // trial subtraction succeeds, giving an all-ones quotient and leaving
    // the dividend as the remainder.
    always_comb begin
        busy_d  = busy_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        b_d     = b_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        sum     = {1'b0, hi_q} + {1'b0, b_q};
        shifted = {hi_q, lo_q[W-1]};
        trial   = shifted - {1'b0, b_q};
        done_o  = busy_q && (cnt_q == LAST) && !flush_i;

        if (flush_i) begin
            busy_d = 1'b0;
        end else if (start_i) begin
            busy_d = 1'b1;
            div_d  = div_i;
            cnt_d  = '0;
            b_d    = b_i;
            lo_d   = a_i;
            hi_d   = '0;
        end else if (busy_q) begin
            if (div_q) begin
                if (!trial[W]) begin
                    hi_d = trial[W-1:0];
                    lo_d = {lo_q[W-2:0], 1'b1};
                end else begin
                    hi_d = shifted[W-1:0];
                    lo_d = {lo_q[W-2:0], 1'b0};
                end
            end else begin
                if (lo_q[0]) begin
                    hi_d = sum[W:1];
                    lo_d = {sum[0], lo_q[W-1:1]};
                end else begin
                    hi_d = {1'b0, hi_q[W-1:1]};
                    lo_d = {hi_q[0], lo_q[W-1:1]};
                end
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
                busy_d = 1'b0;
            end
        end

        lo_o = lo_d;
        hi_o = hi_d;
    end

    // Engine state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            div_q  <= 1'b0;
            cnt_q  <= '0;
            b_q    <= '0;
            lo_q   <= '0;
            hi_q   <= '0;
        end else begin
            busy_q <= busy_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            b_q    <= b_d;
            lo_q   <= lo_d;
            hi_q   <= hi_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/exec_stage_mc.sv
// ---------------------------------------------------------------------------
// exec_stage_mc
// Pipeline execute stage with operand forwarding, a single-cycle ALU and an
// iterative MULU/DIVU engine. Valid/ready handshakes on both sides let the
// multi-cycle ops stall the upstream stage.
// Ports:
//   clk, rst   clock (posedge) / asynchronous active-high reset
//   bus        exec_stage_mc_if.slave: ID/EX op and operands, MEM/WB
//              forwarding taps, flush, and the EX/MEM outputs (result, hi,
//              zero, branch target, store data, dst, WB/MEM control, ill)
// Optional feature macro: EXE_DIV_EN -- DIVU runs on the iterative divider;
// otherwise DIVU retires in one cycle with result 0 and ill_o set.
// ---------------------------------------------------------------------------
module exec_stage_mc
    import exe_pkg::*;
#(
    parameter int W  = 32,
    parameter int RW = 5
) (
    input  logic clk,
    input  logic rst,
    exec_stage_mc_if.slave bus
);
    localparam int SHW = $clog2(W);

    state_t        state_q, state_d;
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  result_q, result_d;
    logic [W-1:0]  hi_q, hi_d;
    logic          zero_q, zero_d;
    logic [W-1:0]  br_target_q, br_target_d;
    logic [W-1:0]  store_val_q, store_val_d;
    logic [RW-1:0] dst_q, dst_d;
    logic [1:0]    wb_ctl_q, wb_ctl_d;
    logic [2:0]    mem_ctl_q, mem_ctl_d;
    logic          ill_q, ill_d;

    alu_op_t       op;
    logic [1:0]    a_sel, b_sel;
    logic [W-1:0]  a_val, rt_fwd, b_val, alu_res;
    logic          alu_ill;
    logic          accept, multi, md_start, md_div, md_busy, md_done;
    logic [W-1:0]  md_lo, md_hi;

    assign op = alu_op_t'(bus.op_i);

    function automatic logic [1:0] fwd_sel(input logic [RW-1:0] src);
        if (bus.mem_wr_i && (bus.mem_rd_i == src) && (src != '0)) return SEL_MEM;
        if (bus.wb_wr_i && (bus.wb_rd_i == src) && (src != '0)) return SEL_WB;
        return SEL_RF;
    endfunction

    // Forwarding: the MEM-stage value is younger than the WB-stage value, so
    // it wins. Register 0 is never forwarded. These values only matter at
    // accept; the engine keeps its own copy for multi-cycle ops.
    always_comb begin
        a_sel = fwd_sel(bus.rs_i);
        b_sel = fwd_sel(bus.rt_i);
        case (a_sel)
            SEL_MEM: a_val = bus.mem_val_i;
            SEL_WB:  a_val = bus.wb_val_i;
            default: a_val = bus.rs_val_i;
        endcase
        case (b_sel)
            SEL_MEM: rt_fwd = bus.mem_val_i;
            SEL_WB:  rt_fwd = bus.wb_val_i;
            default: rt_fwd = bus.rt_val_i;
        endcase
        b_val = bus.use_imm_i ? bus.imm_i : rt_fwd;
    end

    // Single-cycle ALU. Opcodes with no single-cycle meaning in this build
    // produce 0 and flag ill; engine opcodes produce nothing here.
    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (op)
            ALU_ADD:  alu_res = a_val + b_val;
            ALU_SUB:  alu_res = a_val - b_val;
            ALU_AND:  alu_res = a_val & b_val;
            ALU_OR:   alu_res = a_val | b_val;
            ALU_XOR:  alu_res = a_val ^ b_val;
            ALU_NOR:  alu_res = ~(a_val | b_val);
            ALU_SLT:  alu_res = {{(W-1){1'b0}}, ($signed(a_val) < $signed(b_val))};
            ALU_SLTU: alu_res = {{(W-1){1'b0}}, (a_val < b_val)};
            ALU_SLL:  alu_res = a_val << b_val[SHW-1:0];
            ALU_SRL:  alu_res = a_val >> b_val[SHW-1:0];
            ALU_SRA:  alu_res = $signed(a_val) >>> b_val[SHW-1:0];
            ALU_LUI:  alu_res = b_val << (W / 2);
            ALU_MULU: alu_res = '0;
`ifdef EXE_DIV_EN
            ALU_DIVU: alu_res = '0;
`endif
            default:  alu_ill = 1'b1;
        endcase
    end

    assign bus.in_ready_o = (state_q == ST_IDLE) && !md_busy &&
                            (!bus.out_valid_o || bus.out_ready_i) && !bus.flush_i;

    // Stage control. The sideband outputs (dst, ctl, branch target, store
    // data) are loaded at accept even for engine ops: out_valid_o is low for
    // the whole iteration, so nothing downstream observes them early.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        hi_d        = hi_q;
        zero_d      = zero_q;
        br_target_d = br_target_q;
        store_val_d = store_val_q;
        dst_d       = dst_q;
        wb_ctl_d    = wb_ctl_q;
        mem_ctl_d   = mem_ctl_q;
        ill_d       = ill_q;

        accept   = bus.in_valid_i && bus.in_ready_o;
        multi    = is_multi(op);
        md_start = accept && multi;
`ifdef EXE_DIV_EN
        md_div   = (op == ALU_DIVU);
`else
        md_div   = 1'b0;
`endif

        if (bus.flush_i) begin
            out_valid_d = 1'b0;
            state_d     = ST_IDLE;
        end else begin
            if (bus.out_ready_i) begin
                out_valid_d = 1'b0;
            end
            if (accept) begin
                br_target_d = bus.pc_i + (bus.imm_i << 2);
                store_val_d = rt_fwd;
                dst_d       = bus.dst_i;
                wb_ctl_d    = bus.wb_ctl_i;
                mem_ctl_d   = bus.mem_ctl_i;
                if (multi) begin
`ifdef EXE_DIV_EN
                    state_d = md_div ? ST_DIV : ST_MUL;
`else
                    state_d = ST_MUL;
`endif
                end else begin
                    result_d    = alu_res;
                    hi_d        = '0;
                    zero_d      = (alu_res == '0);
                    ill_d       = alu_ill;
                    out_valid_d = 1'b1;
                end
            end
            if (md_done) begin
                result_d    = md_lo;
                hi_d        = md_hi;
                zero_d      = (md_lo == '0);
                ill_d       = 1'b0;
                out_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
        end
    end

    // Stage registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            hi_q        <= '0;
            zero_q      <= 1'b0;
            br_target_q <= '0;
            store_val_q <= '0;
            dst_q       <= '0;
            wb_ctl_q    <= '0;
            mem_ctl_q   <= '0;
            ill_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            hi_q        <= hi_d;
            zero_q      <= zero_d;
            br_target_q <= br_target_d;
            store_val_q <= store_val_d;
            dst_q       <= dst_d;
            wb_ctl_q    <= wb_ctl_d;
            mem_ctl_q   <= mem_ctl_d;
            ill_q       <= ill_d;
        end
    end

    exe_muldiv_iter #(.W(W)) u_muldiv (
        .clk     (clk),
        .rst     (rst),
        .flush_i (bus.flush_i),
        .start_i (md_start),
        .div_i   (md_div),
        .a_i     (a_val),
        .b_i     (b_val),
        .busy_o  (md_busy),
        .done_o  (md_done),
        .lo_o    (md_lo),
        .hi_o    (md_hi)
    );

    assign bus.out_valid_o = out_valid_q;
    assign bus.result_o    = result_q;
    assign bus.hi_o        = hi_q;
    assign bus.zero_o      = zero_q;
    assign bus.br_target_o = br_target_q;
    assign bus.store_val_o = store_val_q;
    assign bus.dst_o       = dst_q;
    assign bus.wb_ctl_o    = wb_ctl_q;
    assign bus.mem_ctl_o   = mem_ctl_q;
    assign bus.ill_o       = ill_q;

endmodule
